// File: rtl/projectile_engine_if.sv
// Throw-control / draw-side bundle for the projectile engine.
// The master side issues throws; the slave side (the engine) reports particle, HP and game state.
interface projectile_engine_if #(
  parameter int POS_W = 12,
  parameter int SPD_W = 5,
  parameter int HP_W  = 7
);
  logic             throw_start;
  logic             turn;
  logic [SPD_W-1:0] speed_x;
  logic [SPD_W-1:0] speed_y;
  logic [3:0]       wind;
  logic [POS_W-1:0] xpos_particle;
  logic [POS_W-1:0] ypos_particle;
  logic [HP_W-1:0]  hp_player1;
  logic [HP_W-1:0]  hp_player2;
  logic             busy;
  logic             end_throw;
  logic [1:0]       hit_result;
  logic             game_over;
  logic [1:0]       winner;

  modport master (
    output throw_start, turn, speed_x, speed_y, wind,
    input  xpos_particle, ypos_particle, hp_player1, hp_player2,
           busy, end_throw, hit_result, game_over, winner
  );

  modport slave (
    input  throw_start, turn, speed_x, speed_y, wind,
    output xpos_particle, ypos_particle, hp_player1, hp_player2,
           busy, end_throw, hit_result, game_over, winner
  );
endinterface

// File: rtl/projectile_engine.sv
// Ballistic throw engine: integrates the trajectory on motion ticks, classifies the landing,
// applies saturating damage and latches game-over / winner.
module projectile_engine #(
  parameter int TICK_DIV = 500000,
  parameter int POS_W    = 12,
  parameter int SPD_W    = 5,
  parameter int HP_W     = 7,
  parameter int HP_INIT  = 100,
  parameter int GRAVITY  = 1,
  parameter int P1_X     = 262,
  parameter int P2_X     = 712,
  parameter int LAUNCH_Y = 400,
  parameter int GROUND_Y = 760,
  parameter int WALL_XL  = 497,
  parameter int WALL_XR  = 527,
  parameter int WALL_Y   = 384,
  parameter int X_MAX    = 1023,
  parameter int P1_ZL    = 112,
  parameter int P1_ZR    = 262,
  parameter int P1_CL    = 162,
  parameter int P1_CR    = 212,
  parameter int P2_ZL    = 712,
  parameter int P2_ZR    = 862,
  parameter int P2_CL    = 762,
  parameter int P2_CR    = 812,
  parameter int DMG_HIT  = 10,
  parameter int DMG_CRIT = 30,
  parameter int PARK_X   = 1025,
  parameter int PARK_Y   = 768
) (
  input  logic                clk60MHz,
  input  logic                rst,
  projectile_engine_if.slave  bus
);
  localparam int X_W   = POS_W + 2;
  localparam int V_W   = POS_W + 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] RES_MISS = 2'b00;
  localparam logic [1:0] RES_WALL = 2'b01;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_CRIT = 2'b11;

  typedef enum logic [1:0] {IDLE, FLIGHT, RESOLVE, OVER} state_t;

  state_t                  state_reg, state_next;
  logic signed [X_W-1:0]   x_reg, y_reg;
  logic signed [V_W-1:0]   vy_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    turn_reg;
  logic [SPD_W-1:0]        sx_reg;
  logic [3:0]              wind_reg;
  logic [1:0]              res_reg, res_next;
  logic [HP_W-1:0]         hp1_reg, hp2_reg;
  logic                    end_throw_reg;
  logic [1:0]              hit_result_reg;
  logic                    game_over_reg;
  logic [1:0]              winner_reg;

  int                      x_i, y_i;
  logic                    tick;
  logic [1:0]              zone_res;
  logic [HP_W-1:0]         dmg, hp_tgt, hp_after;
  logic signed [X_W-1:0]   sx_ext, wind_ext, step;

  always_comb begin
    x_i      = int'(x_reg);
    y_i      = int'(y_reg);
    tick     = (cnt_reg == CNT_W'(TICK_DIV - 1));
    sx_ext   = X_W'(sx_reg);
    wind_ext = {{(X_W-4){wind_reg[3]}}, wind_reg};
    step     = (turn_reg ? -sx_ext : sx_ext) + wind_ext;

    // The target is always the opponent of the thrower.
    zone_res = RES_MISS;
    if (!turn_reg) begin
      if (x_i >= P2_CL && x_i <= P2_CR)      zone_res = RES_CRIT;
      else if (x_i >= P2_ZL && x_i <= P2_ZR) zone_res = RES_HIT;
    end else begin
      if (x_i >= P1_CL && x_i <= P1_CR)      zone_res = RES_CRIT;
      else if (x_i >= P1_ZL && x_i <= P1_ZR) zone_res = RES_HIT;
    end

    dmg      = (res_reg == RES_CRIT) ? HP_W'(DMG_CRIT) :
               (res_reg == RES_HIT)  ? HP_W'(DMG_HIT)  : '0;
    hp_tgt   = turn_reg ? hp1_reg : hp2_reg;
    hp_after = (hp_tgt > dmg) ? (hp_tgt - dmg) : '0;

    state_next = state_reg;
    res_next   = res_reg;
    case (state_reg)
      IDLE:    if (bus.throw_start) state_next = FLIGHT;
      FLIGHT: begin
        // Collisions are tested on the registered position, ahead of any tick.
        if (x_i >= WALL_XL && x_i <= WALL_XR && y_i >= WALL_Y) begin
          state_next = RESOLVE;
          res_next   = RES_WALL;
        end else if (x_i < 0 || x_i > X_MAX) begin
          state_next = RESOLVE;
          res_next   = RES_MISS;
        end else if (y_i >= GROUND_Y) begin
          state_next = RESOLVE;
          res_next   = zone_res;
        end
      end
      RESOLVE: state_next = (hp_after == '0) ? OVER : IDLE;
      OVER:    state_next = OVER;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_reg      <= IDLE;
      x_reg          <= X_W'(PARK_X);
      y_reg          <= X_W'(PARK_Y);
      vy_reg         <= '0;
      cnt_reg        <= '0;
      turn_reg       <= 1'b0;
      sx_reg         <= '0;
      wind_reg       <= '0;
      res_reg        <= RES_MISS;
      hp1_reg        <= HP_W'(HP_INIT);
      hp2_reg        <= HP_W'(HP_INIT);
      end_throw_reg  <= 1'b0;
      hit_result_reg <= RES_MISS;
      game_over_reg  <= 1'b0;
      winner_reg     <= 2'b00;
    end else begin
      state_reg     <= state_next;
      res_reg       <= res_next;
      end_throw_reg <= 1'b0;
      case (state_reg)
        IDLE: if (bus.throw_start) begin
          turn_reg <= bus.turn;
          sx_reg   <= bus.speed_x;
          wind_reg <= bus.wind;
          x_reg    <= bus.turn ? X_W'(P2_X) : X_W'(P1_X);
          y_reg    <= X_W'(LAUNCH_Y);
          vy_reg   <= V_W'(bus.speed_y);
          cnt_reg  <= '0;
        end
        FLIGHT: if (state_next == FLIGHT) begin
          if (tick) begin
            x_reg   <= x_reg + step;
            y_reg   <= y_reg - X_W'(vy_reg);
            vy_reg  <= vy_reg - V_W'(GRAVITY);
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESOLVE: begin
          hit_result_reg <= res_reg;
          end_throw_reg  <= 1'b1;
          x_reg          <= X_W'(PARK_X);
          y_reg          <= X_W'(PARK_Y);
          if (turn_reg) hp1_reg <= hp_after;
          else          hp2_reg <= hp_after;
          if (hp_after == '0) begin
            game_over_reg <= 1'b1;
            winner_reg    <= turn_reg ? 2'b10 : 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.xpos_particle = x_reg[POS_W-1:0];
  assign bus.ypos_particle = (y_reg < 0) ? '0 : y_reg[POS_W-1:0];
  assign bus.hp_player1    = hp1_reg;
  assign bus.hp_player2    = hp2_reg;
  assign bus.busy          = (state_reg == FLIGHT) || (state_reg == RESOLVE);
  assign bus.end_throw     = end_throw_reg;
  assign bus.hit_result    = hit_result_reg;
  assign bus.game_over     = game_over_reg;
  assign bus.winner        = winner_reg;
endmodule

// File: tb/tb_projectile_engine.sv
// Scoreboard bench: dut_a (gravity 1) plays a full game, dut_b (gravity 0) covers wall,
// out-of-bounds with negative wind, and reset mid-flight.
module tb_projectile_engine;
  localparam int POS_W = 12;
  localparam int SPD_W = 5;
  localparam int HP_W  = 7;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  projectile_engine_if #(.POS_W(POS_W), .SPD_W(SPD_W), .HP_W(HP_W)) bus_a ();
  projectile_engine_if #(.POS_W(POS_W), .SPD_W(SPD_W), .HP_W(HP_W)) bus_b ();

  projectile_engine #(.TICK_DIV(4)) dut_a (
    .clk60MHz(clk), .rst(rst_a), .bus(bus_a)
  );
  projectile_engine #(.TICK_DIV(4), .GRAVITY(0)) dut_b (
    .clk60MHz(clk), .rst(rst_b), .bus(bus_b)
  );

  typedef struct {
    int res; int hp1; int hp2; int go; int win; int lx; int ly;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mhp1_a = 100, mhp2_a = 100, mhp1_b = 100, mhp2_b = 100;
  int   pulses_a = 0, pulses_b = 0;
  int   last_x_a = 0, last_y_a = 0, last_x_b = 0, last_y_b = 0;
  logic prev_end_a = 1'b0, prev_end_b = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard pop on each end_throw pulse; landing position is the last value seen while busy.
  always @(negedge clk) begin
    if (!rst_a && bus_a.end_throw === 1'b1) begin
      pulses_a++;
      check_eq("a_single_pulse", int'(prev_end_a), 0);
      if (q_a.size() == 0) check_eq("a_unexpected_end", 1, 0);
      else begin
        ea = q_a.pop_front();
        check_eq("a_hit_result", int'(bus_a.hit_result), ea.res);
        check_eq("a_hp1", int'(bus_a.hp_player1), ea.hp1);
        check_eq("a_hp2", int'(bus_a.hp_player2), ea.hp2);
        check_eq("a_game_over", int'(bus_a.game_over), ea.go);
        check_eq("a_winner", int'(bus_a.winner), ea.win);
        check_eq("a_land_x", last_x_a, ea.lx);
        check_eq("a_land_y", last_y_a, ea.ly);
        check_eq("a_park_x", int'(bus_a.xpos_particle), 1025);
        check_eq("a_park_y", int'(bus_a.ypos_particle), 768);
        check_eq("a_busy_after", int'(bus_a.busy), 0);
      end
    end
    if (bus_a.busy === 1'b1) begin
      last_x_a = int'(bus_a.xpos_particle);
      last_y_a = int'(bus_a.ypos_particle);
    end
    prev_end_a = bus_a.end_throw;
  end

  always @(negedge clk) begin
    if (!rst_b && bus_b.end_throw === 1'b1) begin
      pulses_b++;
      check_eq("b_single_pulse", int'(prev_end_b), 0);
      if (q_b.size() == 0) check_eq("b_unexpected_end", 1, 0);
      else begin
        eb = q_b.pop_front();
        check_eq("b_hit_result", int'(bus_b.hit_result), eb.res);
        check_eq("b_hp1", int'(bus_b.hp_player1), eb.hp1);
        check_eq("b_hp2", int'(bus_b.hp_player2), eb.hp2);
        check_eq("b_game_over", int'(bus_b.game_over), eb.go);
        check_eq("b_land_x", last_x_b, eb.lx);
        check_eq("b_land_y", last_y_b, eb.ly);
      end
    end
    if (bus_b.busy === 1'b1) begin
      last_x_b = int'(bus_b.xpos_particle);
      last_y_b = int'(bus_b.ypos_particle);
    end
    prev_end_b = bus_b.end_throw;
  end

  // One-cycle throw_start; inputs are scrambled afterwards since the engine must hold its copy.
  task automatic pulse_throw(input bit sel, input logic t, input int sx, input int sy, input int w);
    @(negedge clk);
    if (!sel) begin
      bus_a.turn = t; bus_a.speed_x = sx[4:0]; bus_a.speed_y = sy[4:0]; bus_a.wind = w[3:0];
      bus_a.throw_start = 1'b1;
    end else begin
      bus_b.turn = t; bus_b.speed_x = sx[4:0]; bus_b.speed_y = sy[4:0]; bus_b.wind = w[3:0];
      bus_b.throw_start = 1'b1;
    end
    @(negedge clk);
    bus_a.throw_start = 1'b0; bus_a.turn = ~bus_a.turn; bus_a.speed_x = 5'd31;
    bus_a.speed_y = 5'd3; bus_a.wind = 4'h7;
    bus_b.throw_start = 1'b0; bus_b.turn = ~bus_b.turn; bus_b.speed_x = 5'd31;
    bus_b.speed_y = 5'd3; bus_b.wind = 4'h7;
  endtask

  task automatic start_throw(input bit sel, input logic t, input int sx, input int sy,
                             input int w, input int res, input int lx, input int ly);
    exp_t e;
    int   dmg;
    dmg = (res == 3) ? 30 : (res == 2) ? 10 : 0;
    if (!sel) begin
      if (t) mhp1_a = (mhp1_a > dmg) ? mhp1_a - dmg : 0;
      else   mhp2_a = (mhp2_a > dmg) ? mhp2_a - dmg : 0;
      e.hp1 = mhp1_a; e.hp2 = mhp2_a;
    end else begin
      if (t) mhp1_b = (mhp1_b > dmg) ? mhp1_b - dmg : 0;
      else   mhp2_b = (mhp2_b > dmg) ? mhp2_b - dmg : 0;
      e.hp1 = mhp1_b; e.hp2 = mhp2_b;
    end
    e.res = res; e.lx = lx; e.ly = ly;
    e.go  = (e.hp1 == 0 || e.hp2 == 0) ? 1 : 0;
    e.win = (e.go == 0) ? 0 : (t ? 2 : 1);
    if (!sel) q_a.push_back(e); else q_b.push_back(e);
    pulse_throw(sel, t, sx, sy, w);
  endtask

  task automatic wait_drain(input bit sel, input int budget);
    int n = 0;
    while (((!sel) ? q_a.size() : q_b.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(sel ? "b_throw_done" : "a_throw_done", (!sel) ? q_a.size() : q_b.size(), 0);
    if (!sel) q_a.delete(); else q_b.delete();
    @(negedge clk);
    check_eq(sel ? "b_end_low" : "a_end_low",
             int'((!sel) ? bus_a.end_throw : bus_b.end_throw), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.throw_start = 1'b0; bus_a.turn = 1'b0; bus_a.speed_x = '0; bus_a.speed_y = '0; bus_a.wind = '0;
    bus_b.throw_start = 1'b0; bus_b.turn = 1'b0; bus_b.speed_x = '0; bus_b.speed_y = '0; bus_b.wind = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    check_eq("rst_hp1", int'(bus_a.hp_player1), 100);
    check_eq("rst_hp2", int'(bus_a.hp_player2), 100);
    check_eq("rst_x", int'(bus_a.xpos_particle), 1025);
    check_eq("rst_y", int'(bus_a.ypos_particle), 768);
    check_eq("rst_busy", int'(bus_a.busy), 0);
    check_eq("rst_hit_result", int'(bus_a.hit_result), 0);
    check_eq("rst_game_over", int'(bus_a.game_over), 0);
    check_eq("rst_winner", int'(bus_a.winner), 0);
    check_eq("rst_end_throw", int'(bus_a.end_throw), 0);

    // Player 1 crit over the wall, with a mid-flight position probe at tick 24.
    start_throw(0, 1'b0, 10, 20, 0, 3, 812, 785);
    repeat (96) @(posedge clk);
    @(negedge clk);
    check_eq("tick24_x", int'(bus_a.xpos_particle), 502);
    check_eq("tick24_y", int'(bus_a.ypos_particle), 196);
    check_eq("tick24_busy", int'(bus_a.busy), 1);
    wait_drain(0, 400);

    start_throw(0, 1'b0, 9, 20, 0, 2, 757, 785);   wait_drain(0, 400);
    start_throw(0, 1'b1, 10, 20, 0, 3, 162, 785);  wait_drain(0, 400);
    start_throw(0, 1'b0, 10, 20, 0, 3, 812, 785);  wait_drain(0, 400);
    start_throw(0, 1'b0, 9, 20, 0, 2, 757, 785);   wait_drain(0, 400);
    // hp2 is 20 here: a crit must saturate to 0 and end the game.
    start_throw(0, 1'b0, 10, 20, 0, 3, 812, 785);  wait_drain(0, 400);

    pulse_throw(0, 1'b0, 10, 20, 0);
    repeat (10) @(negedge clk);
    check_eq("over_busy", int'(bus_a.busy), 0);
    check_eq("over_game_over", int'(bus_a.game_over), 1);
    check_eq("over_winner", int'(bus_a.winner), 1);
    check_eq("over_hp1", int'(bus_a.hp_player1), 70);
    check_eq("over_hp2", int'(bus_a.hp_player2), 0);
    check_eq("a_pulse_count", pulses_a, 6);

    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check_eq("rerst_game_over", int'(bus_a.game_over), 0);
    check_eq("rerst_winner", int'(bus_a.winner), 0);
    check_eq("rerst_hp2", int'(bus_a.hp_player2), 100);

    // Negative wind drives x below 0 on tick 33: miss, x seen as 4094 (-2 in 12 bits).
    start_throw(1, 1'b0, 0, 0, -8, 0, 4094, 400);  wait_drain(1, 400);
    // Flat trajectory reaches the wall at x = 497.
    start_throw(1, 1'b0, 5, 0, 0, 1, 497, 400);    wait_drain(1, 400);
    check_eq("wall_hit_result", int'(bus_b.hit_result), 1);
    check_eq("wall_hp2", int'(bus_b.hp_player2), 100);

    pulse_throw(1, 1'b0, 5, 0, 0);
    repeat (20) @(negedge clk);
    check_eq("mid_busy", int'(bus_b.busy), 1);
    rst_b = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_x", int'(bus_b.xpos_particle), 1025);
    check_eq("mid_rst_y", int'(bus_b.ypos_particle), 768);
    check_eq("mid_rst_busy", int'(bus_b.busy), 0);
    check_eq("mid_rst_hit_result", int'(bus_b.hit_result), 0);
    rst_b = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("mid_rst_idle", int'(bus_b.busy), 0);
    check_eq("b_pulse_count", pulses_b, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
